// File: rtl/fifo_burst_reader_pkg.sv
// Shared constants and FSM state encoding for the FIFO burst reader.
package fifo_burst_reader_pkg;

  localparam int DATA_W     = 32;
  localparam int CNT_W      = 4;
  localparam int MAX_BURST  = 8;
  localparam int SKID_DEPTH = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/fifo_burst_reader_skid_buf.sv
// Two-entry buffer between the FIFO read port and the valid/ready stream.
module reader_skid_buf #(
  parameter int DATA_W = fifo_burst_reader_pkg::DATA_W
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [1:0]        occ,
  output logic [DATA_W-1:0] head
);
  import fifo_burst_reader_pkg::*;

  logic [DATA_W-1:0] mem [SKID_DEPTH];
  logic              wr_ptr;
  logic              rd_ptr;
  logic              do_push;
  logic              do_pop;

  assign do_pop  = pop && (occ != 2'd0);
  // A full buffer still takes a push when the head leaves in the same cycle.
  assign do_push = push && ((occ != 2'd2) || do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < SKID_DEPTH; i++) begin
        mem[i] <= '0;
      end
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      occ    <= 2'd0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= ~wr_ptr;
      end
      if (do_pop) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({do_push, do_pop})
        2'b10:   occ <= occ + 2'd1;
        2'b01:   occ <= occ - 2'd1;
        default: occ <= occ;
      endcase
    end
  end

endmodule

// File: rtl/fifo_burst_reader.sv
// Drains a programmed burst from the 8-deep FIFO and re-presents it on a valid/ready stream.
module fifo_burst_reader #(
  parameter int DATA_W    = fifo_burst_reader_pkg::DATA_W,
  parameter int CNT_W     = fifo_burst_reader_pkg::CNT_W,
  parameter int MAX_BURST = fifo_burst_reader_pkg::MAX_BURST
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [CNT_W-1:0]  burst_len,
  output logic              fifo_rd_en,
  input  logic [DATA_W-1:0] fifo_dout,
  input  logic              fifo_empty,
  input  logic              fifo_rd_ack,
  input  logic              fifo_rd_err,
  output logic              m_valid,
  output logic [DATA_W-1:0] m_data,
  input  logic              m_ready,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [CNT_W-1:0]  rcv_count
);
  import fifo_burst_reader_pkg::*;

  state_t           state;
  logic [CNT_W-1:0] len;
  logic [CNT_W-1:0] issued;
  logic             inflight;
  logic             rd_abort;
  logic [1:0]       occ;
  logic             push;
  logic             pop;
  logic             space_ok;

  assign m_valid = (occ != 2'd0);
  assign pop     = m_valid && m_ready;
  assign push    = fifo_rd_ack && inflight;

  // The word popped this cycle frees the slot the next read will land in,
  // which is what lets reads run back to back while m_ready stays high.
  assign space_ok = ({1'b0, occ} + {2'b00, inflight}) < (3'd2 + {2'b00, pop});

  assign fifo_rd_en = (state == READ) && (issued < len) && !fifo_empty &&
                      space_ok && !rd_abort && !fifo_rd_err;

  reader_skid_buf #(.DATA_W(DATA_W)) u_skid (
    .clk      (clk),
    .reset_n  (reset_n),
    .push     (push),
    .push_data(fifo_dout),
    .pop      (pop),
    .occ      (occ),
    .head     (m_data)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      len       <= '0;
      issued    <= '0;
      rcv_count <= '0;
      inflight  <= 1'b0;
      rd_abort  <= 1'b0;
      err       <= 1'b0;
      done      <= 1'b0;
      busy      <= 1'b0;
    end else begin
      done     <= 1'b0;
      inflight <= fifo_rd_en;
      if (fifo_rd_en) begin
        issued <= issued + CNT_W'(1);
      end
      if (push) begin
        rcv_count <= rcv_count + CNT_W'(1);
      end
      if (fifo_rd_ack && !inflight) begin
        err <= 1'b1;
      end
      if (fifo_rd_err && (state != IDLE)) begin
        err      <= 1'b1;
        rd_abort <= 1'b1;
      end
      case (state)
        IDLE: begin
          if (start) begin
            len       <= (burst_len > CNT_W'(MAX_BURST)) ? CNT_W'(MAX_BURST) : burst_len;
            issued    <= '0;
            rcv_count <= '0;
            err       <= 1'b0;
            rd_abort  <= 1'b0;
            busy      <= 1'b1;
            state     <= (burst_len == '0) ? DONE : READ;
          end
        end
        READ: begin
          if (rd_abort || (issued == len)) begin
            state <= DRAIN;
          end
        end
        DRAIN: begin
          // After an abort the burst ends once the last in-flight word has drained.
          if ((occ == 2'd0) && (rd_abort ? !inflight : (rcv_count == len))) begin
            state <= DONE;
          end
        end
        DONE: begin
          state <= IDLE;
          done  <= 1'b1;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_burst_reader.sv
// Bench for fifo_burst_reader: behavioural FIFO plus a word-order reference queue.
module tb_fifo_burst_reader;

  logic        clk;
  logic        reset_n;
  logic        start;
  logic [3:0]  burst_len;
  logic        fifo_rd_en;
  logic [31:0] fifo_dout;
  logic        fifo_empty;
  logic        fifo_rd_ack;
  logic        fifo_rd_err;
  logic        m_valid;
  logic [31:0] m_data;
  logic        m_ready;
  logic        busy;
  logic        done;
  logic        err;
  logic [3:0]  rcv_count;

  logic        ack_q;
  logic        spur_ack;
  logic        rd_en_s;
  logic [31:0] fq[$];
  logic [31:0] wq[$];
  logic [31:0] exp_q[$];
  logic [31:0] got[$];

  int compared;
  int mismatched;
  int cyc, rd_cnt, run, max_run, done_cnt, busy_cnt, rd_empty_cnt, unstable_cnt;
  int acks, pops, max_occ, first_pop, last_pop, done_cyc, start_cyc, rd_after_err;
  bit err_seen;
  bit prev_stall;
  logic [31:0] prev_data;

  fifo_burst_reader dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .start      (start),
    .burst_len  (burst_len),
    .fifo_rd_en (fifo_rd_en),
    .fifo_dout  (fifo_dout),
    .fifo_empty (fifo_empty),
    .fifo_rd_ack(fifo_rd_ack),
    .fifo_rd_err(fifo_rd_err),
    .m_valid    (m_valid),
    .m_data     (m_data),
    .m_ready    (m_ready),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .rcv_count  (rcv_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign fifo_rd_ack = ack_q | spur_ack;

  // Behavioural 8-deep FIFO with one-cycle registered read data.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fq.delete();
      wq.delete();
      ack_q      <= 1'b0;
      fifo_dout  <= '0;
      fifo_empty <= 1'b1;
    end else begin
      ack_q <= 1'b0;
      if (rd_en_s && fq.size() > 0) begin
        fifo_dout <= fq.pop_front();
        ack_q     <= 1'b1;
      end
      while (wq.size() > 0 && fq.size() < 8) fq.push_back(wq.pop_front());
      fifo_empty <= (fq.size() == 0);
    end
  end

  // Mid-cycle monitor: collects stream words and per-burst statistics.
  always @(negedge clk) begin
    cyc++;
    rd_en_s = fifo_rd_en;
    if (reset_n) begin
      if (start) start_cyc = cyc;
      if (fifo_rd_err) err_seen = 1;
      if (fifo_rd_en) begin
        rd_cnt++;
        run++;
        if (run > max_run) max_run = run;
        if (fifo_empty) rd_empty_cnt++;
        if (err_seen) rd_after_err++;
      end else begin
        run = 0;
      end
      if (acks - pops > max_occ) max_occ = acks - pops;
      if (fifo_rd_ack) acks++;
      if (m_valid && m_ready) begin
        got.push_back(m_data);
        pops++;
        if (first_pop < 0) first_pop = cyc;
        last_pop = cyc;
      end
      if (prev_stall && (m_valid !== 1'b1 || m_data !== prev_data)) unstable_cnt++;
      prev_stall = m_valid && !m_ready;
      prev_data  = m_data;
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (busy) busy_cnt++;
    end
  end

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    compared++;
    assert (obs === exp_v) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp_v);
    end
  endtask

  task automatic clear_monitor();
    rd_cnt = 0; run = 0; max_run = 0; done_cnt = 0; busy_cnt = 0;
    rd_empty_cnt = 0; unstable_cnt = 0; acks = 0; pops = 0; max_occ = 0;
    first_pop = -1; last_pop = -1; done_cyc = -1; start_cyc = -1;
    rd_after_err = 0; err_seen = 0; prev_stall = 0;
    got.delete();
  endtask

  task automatic fill(input int n);
    logic [31:0] w;
    for (int i = 0; i < n; i++) begin
      w = $urandom;
      wq.push_back(w);
      exp_q.push_back(w);
    end
  endtask

  function automatic logic ready_for(input int mode, input int k);
    case (mode)
      0:       return 1'b1;
      1:       return (k % 4 == 0) || (k % 4 == 3);
      default: return 1'($urandom_range(0, 1));
    endcase
  endfunction

  // Runs one burst until done, a requested reset point, or the cycle budget.
  task automatic apply_stimulus(input int len, input int ready_mode, input int late_words,
                                input int late_delay, input int err_after_reads,
                                input int reset_after_pops, output bit timed_out);
    bit err_sent;
    clear_monitor();
    err_sent  = 0;
    timed_out = 1;
    start     = 1'b1;
    burst_len = len[3:0];
    m_ready   = ready_for(ready_mode, 0);
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 1; k < 400; k++) begin
      m_ready     = ready_for(ready_mode, k);
      fifo_rd_err = 1'b0;
      if (late_words > 0 && k == late_delay) fill(late_words);
      if (!err_sent && err_after_reads >= 0 && rd_cnt >= err_after_reads) begin
        fifo_rd_err = 1'b1;
        err_sent    = 1;
      end
      if ((reset_after_pops >= 0 && got.size() >= reset_after_pops) || done_cnt > 0) begin
        timed_out = 0;
        break;
      end
      @(posedge clk); #1;
    end
    fifo_rd_err = 1'b0;
  endtask

  task automatic finish_burst(input string tag, input int n, input bit exp_err, input bit timed_out);
    logic [31:0] exp_w;
    logic [31:0] obs_w;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_output({tag, "_timeout"}, 32'(timed_out), 32'd0);
    check_output({tag, "_done_once"}, done_cnt, 32'd1);
    check_output({tag, "_words"}, got.size(), n);
    check_output({tag, "_reads"}, rd_cnt, n);
    check_output({tag, "_rcv_count"}, 32'(rcv_count), n);
    check_output({tag, "_err"}, 32'(err), 32'(exp_err));
    check_output({tag, "_rd_while_empty"}, rd_empty_cnt, 32'd0);
    for (int i = 0; i < n; i++) begin
      exp_w = exp_q.pop_front();
      obs_w = 'x;
      if (i < got.size()) obs_w = got[i];
      check_output($sformatf("%s_word%0d", tag, i), obs_w, exp_w);
    end
    @(posedge clk); #1;
  endtask

  task automatic check_all_zero(input string tag);
    check_output({tag, "_rd_en"}, 32'(fifo_rd_en), 32'd0);
    check_output({tag, "_m_valid"}, 32'(m_valid), 32'd0);
    check_output({tag, "_m_data"}, m_data, 32'd0);
    check_output({tag, "_busy"}, 32'(busy), 32'd0);
    check_output({tag, "_done"}, 32'(done), 32'd0);
    check_output({tag, "_err"}, 32'(err), 32'd0);
    check_output({tag, "_rcv_count"}, 32'(rcv_count), 32'd0);
  endtask

  initial begin
    bit to;
    int len;
    int eff;
    compared = 0; mismatched = 0; cyc = 0;
    clear_monitor();
    start = 0; burst_len = 0; m_ready = 0; fifo_rd_err = 0; spur_ack = 0;
    rd_en_s = 0; reset_n = 1'b1;
    #2 reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #3 reset_n = 1'b1;
    @(negedge clk);
    check_all_zero("reset");

    $display("[TB] burst of 5 from a preloaded FIFO");
    @(posedge clk); #1;
    fill(5);
    repeat (3) @(posedge clk); #1;
    apply_stimulus(5, 0, 0, 0, -1, -1, to);
    finish_burst("t1", 5, 0, to);
    check_output("t1_read_run", max_run, 32'd5);
    check_output("t1_no_bubbles", last_pop - first_pop + 1, 32'd5);

    $display("[TB] burst of 4 with the FIFO running dry");
    fill(2);
    repeat (3) @(posedge clk); #1;
    apply_stimulus(4, 0, 2, 10, -1, -1, to);
    finish_burst("t2", 4, 0, to);
    check_output("t2_done_after_last", 32'(done_cyc > last_pop), 32'd1);

    $display("[TB] burst of 8 with m_ready pattern 1,0,0,1");
    fill(8);
    repeat (3) @(posedge clk); #1;
    apply_stimulus(8, 1, 0, 0, -1, -1, to);
    finish_burst("t3", 8, 0, to);
    check_output("t3_occ_le2", 32'(max_occ <= 2), 32'd1);
    check_output("t3_data_stable", unstable_cnt, 32'd0);
    check_output("t3_reads_throttled", 32'(max_run < 8), 32'd1);

    $display("[TB] read error after 3 reads of an 8-word burst");
    fill(8);
    repeat (3) @(posedge clk); #1;
    apply_stimulus(8, 0, 0, 0, 3, -1, to);
    finish_burst("t5", 3, 1, to);
    check_output("t5_no_reads_after_err", rd_after_err, 32'd0);

    $display("[TB] zero-length burst");
    apply_stimulus(0, 0, 0, 0, -1, -1, to);
    finish_burst("t4", 0, 0, to);
    check_output("t4_done_latency", done_cyc - start_cyc, 32'd2);
    check_output("t4_busy_cycles", busy_cnt, 32'd1);

    $display("[TB] reset in the middle of a 6-word burst");
    fill(1);
    repeat (3) @(posedge clk); #1;
    apply_stimulus(6, 0, 0, 0, -1, 2, to);
    check_output("t6_reached_two_words", 32'(to), 32'd0);
    check_output("t6_word0", got[0], exp_q[0]);
    check_output("t6_word1", got[1], exp_q[1]);
    #1 reset_n = 1'b0;
    #1 check_all_zero("t6_async");
    exp_q.delete();
    repeat (2) @(posedge clk);
    #3 reset_n = 1'b1;
    @(negedge clk);
    check_output("t6_idle_busy", 32'(busy), 32'd0);
    @(posedge clk); #1;
    fill(3);
    repeat (3) @(posedge clk); #1;
    apply_stimulus(3, 0, 0, 0, -1, -1, to);
    finish_burst("t6_after", 3, 0, to);

    $display("[TB] random bursts with random backpressure");
    for (int r = 0; r < 5; r++) begin
      len = $urandom_range(1, 12);
      eff = (len > 8) ? 8 : len;
      if (exp_q.size() < eff) fill(eff - exp_q.size() + $urandom_range(0, 2));
      repeat (4) @(posedge clk); #1;
      apply_stimulus(len, 2, 0, 0, -1, -1, to);
      finish_burst($sformatf("rnd%0d_len%0d", r, len), eff, 0, to);
      check_output($sformatf("rnd%0d_occ_le2", r), 32'(max_occ <= 2), 32'd1);
      check_output($sformatf("rnd%0d_data_stable", r), unstable_cnt, 32'd0);
    end

    $display("[TB] acknowledge with no read in flight");
    spur_ack = 1'b1;
    @(posedge clk); #1;
    spur_ack = 1'b0;
    @(negedge clk);
    check_output("spur_err", 32'(err), 32'd1);
    check_output("spur_no_valid", 32'(m_valid), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
